// File: rtl/zxw_serial_addsub_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | zxw_serial_addsub_pkg                                            |
// | State encoding and sizing helpers for the digit-serial add/sub.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package zxw_serial_addsub_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Width of a counter that indexes N/K digits; never narrower than 1 bit.
  function automatic int clog2_min1(input int n, input int k);
    int d;
    d = (k > 0) ? (n / k) : 1;
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fulladd.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fulladd                                                          |
// | One-bit full adder cell.                                         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fulladd (
  input  logic cin,
  input  logic x,
  input  logic y,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule
`default_nettype wire

// File: rtl/zxw_digit_add.sv
`default_nettype none
// +------------------------------------------------------------------+
// | zxw_digit_add                                                    |
// | K-bit ripple adder; also exposes the carry into the top bit.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module zxw_digit_add #(
  parameter int K = 1
) (
  input  logic         carryin,
  input  logic [K-1:0] x,
  input  logic [K-1:0] y,
  output logic [K-1:0] s,
  output logic         carryout,
  output logic         c_top
);

  logic [K:0] w_c;

  assign w_c[0] = carryin;

  for (genvar i = 0; i < K; i++) begin : g_bit
    fulladd u_fa (
      .cin  (w_c[i]),
      .x    (x[i]),
      .y    (y[i]),
      .s    (s[i]),
      .cout (w_c[i+1])
    );
  end

  assign carryout = w_c[K];
  assign c_top    = w_c[K-1];

endmodule
`default_nettype wire

// File: rtl/zxw_serial_addsub.sv
`default_nettype none
// +------------------------------------------------------------------+
// | zxw_serial_addsub                                                |
// | Digit-serial N-bit two's-complement adder/subtractor, K bits/clk.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module zxw_serial_addsub
  import zxw_serial_addsub_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 1
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Sub,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] s,
  output logic         carryout,
  output logic         overflow,
  output logic         Busy,
  output logic         Done
);

  if ((N < 1) || (K < 1) || (K > N) || ((N % ((K < 1) ? 1 : K)) != 0)) begin : g_bad_param
    $error("zxw_serial_addsub: require 1 <= K <= N and N %% K == 0");
  end

  localparam int              C_DIGITS = N / K;
  localparam int              C_CW     = clog2_min1(N, K);
  localparam logic [C_CW-1:0] C_LAST   = C_CW'(C_DIGITS - 1);

  logic [1:0]      r_state;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_acc;
  logic            r_c;
  logic [C_CW-1:0] r_cnt;
  logic [N-1:0]    r_s;
  logic            r_co;
  logic            r_ov;

  logic [K-1:0]    w_dsum;
  logic            w_dcout;
  logic            w_ctop;
  logic [N-1:0]    w_acc_next;

  zxw_digit_add #(.K(K)) u_digit (
    .carryin  (r_c),
    .x        (r_a[K-1:0]),
    .y        (r_b[K-1:0]),
    .s        (w_dsum),
    .carryout (w_dcout),
    .c_top    (w_ctop)
  );

  // Sum digits enter at the MSB end, so after N/K steps the LSB digit sits at bit 0.
  if (K == N) begin : g_full_digit
    assign w_acc_next = w_dsum;
  end else begin : g_part_digit
    assign w_acc_next = {w_dsum, r_acc[N-1:K]};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (Start) begin
            r_a     <= x;
            r_b     <= y ^ {N{Sub}};
            r_c     <= Sub;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_a   <= r_a >> K;
          r_b   <= r_b >> K;
          r_c   <= w_dcout;
          r_cnt <= r_cnt + 1'b1;
          // Visible results are only updated once the whole word is formed.
          if (r_cnt == C_LAST) begin
            r_s     <= w_acc_next;
            r_co    <= w_dcout;
            r_ov    <= w_ctop ^ w_dcout;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s        = r_s;
  assign carryout = r_co;
  assign overflow = r_ov;
  assign Busy     = (r_state == RUN);
  assign Done     = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_zxw_serial_addsub.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_zxw_serial_addsub                                             |
// | Directed and randomised checks over N in {4,8,16}, all valid K.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_zxw_serial_addsub;

  localparam int C_NCFG = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [C_NCFG-1:0] rstart;
  logic              rsub;
  logic [15:0]       rx;
  logic [15:0]       ry;
  logic [15:0]       rs [C_NCFG];
  logic [C_NCFG-1:0] rco;
  logic [C_NCFG-1:0] rov;
  logic [C_NCFG-1:0] rbusy;
  logic [C_NCFG-1:0] rdone;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Config order: (4,1)(4,2)(4,4)(8,1)(8,2)(8,4)(8,8)(16,1)(16,2)(16,4)(16,8)(16,16)
  function automatic int cfg_n(input int i);
    return (i < 3) ? 4 : (i < 7) ? 8 : 16;
  endfunction

  function automatic int cfg_k(input int i);
    return (i < 3) ? (1 << i) : (i < 7) ? (1 << (i - 3)) : (1 << (i - 7));
  endfunction

  for (genvar g = 0; g < C_NCFG; g++) begin : g_cfg
    localparam int NN = cfg_n(g);
    localparam int KK = cfg_k(g);
    logic [NN-1:0] s_w;
    zxw_serial_addsub #(.N(NN), .K(KK)) u_dut (
      .Clock    (clk),
      .Reset    (rst),
      .Start    (rstart[g]),
      .Sub      (rsub),
      .x        (rx[NN-1:0]),
      .y        (ry[NN-1:0]),
      .s        (s_w),
      .carryout (rco[g]),
      .overflow (rov[g]),
      .Busy     (rbusy[g]),
      .Done     (rdone[g])
    );
    assign rs[g] = 16'(s_w);
  end

  // Reference: {overflow, carryout, s} from integer arithmetic on n-bit operands.
  function automatic logic [17:0] model(input int n, input int a, input int b, input bit sub);
    int m, sa, sb, r, lo, hi, sum;
    logic co, ov;
    m  = (1 << n) - 1;
    a  = a & m;
    b  = b & m;
    sa = (a >= (1 << (n - 1))) ? a - (1 << n) : a;
    sb = (b >= (1 << (n - 1))) ? b - (1 << n) : b;
    lo = -(1 << (n - 1));
    hi = (1 << (n - 1)) - 1;
    if (sub) begin
      r   = sa - sb;
      sum = (a - b) & m;
      co  = (a >= b);
    end else begin
      r   = sa + sb;
      sum = (a + b) & m;
      co  = ((a + b) > m);
    end
    ov = (r < lo) || (r > hi);
    return {ov, co, 16'(sum)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation on one instance; optionally pulses Start with x=0 mid-RUN.
  task automatic run_op(input string tag, input int idx, input bit sub,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [17:0] e, input bit mid);
    int lat, cyc;
    lat = cfg_n(idx) / cfg_k(idx);
    cyc = 0;
    rx = a; ry = b; rsub = sub; rstart[idx] = 1'b1;
    @(negedge clk);
    rstart[idx] = 1'b0;
    while (rbusy[idx] && cyc < 64) begin
      cyc++;
      if (mid && cyc == 1) begin
        rstart[idx] = 1'b1;
        rx = 16'h0;
      end else begin
        rstart[idx] = 1'b0;
      end
      @(negedge clk);
    end
    rstart[idx] = 1'b0;
    chk({tag, "_busy_cycles"}, cyc, lat);
    chk({tag, "_done"}, rdone[idx], 1);
    chk({tag, "_s"}, rs[idx], e[15:0]);
    chk({tag, "_co"}, rco[idx], e[16]);
    chk({tag, "_ov"}, rov[idx], e[17]);
    @(negedge clk);
    chk({tag, "_done_pulse"}, rdone[idx], 0);
    chk({tag, "_s_hold"}, rs[idx], e[15:0]);
  endtask

  initial begin
    logic [15:0] a, b, prev;
    logic [17:0] e;
    bit          sb;
    int          cyc;

    rst = 1'b1; rstart = '0; rsub = 1'b0; rx = '0; ry = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < C_NCFG; g++) begin
      chk($sformatf("rst%0d_s", g), rs[g], 0);
      chk($sformatf("rst%0d_co", g), rco[g], 0);
      chk($sformatf("rst%0d_ov", g), rov[g], 0);
      chk($sformatf("rst%0d_busy", g), rbusy[g], 0);
      chk($sformatf("rst%0d_done", g), rdone[g], 0);
    end

    // Directed cases with hand-derived results
    run_op("k1_add", 3, 1'b0, 16'h5A, 16'h3C, {1'b1, 1'b0, 16'h0096}, 1'b0);
    run_op("k4_sub_a", 5, 1'b1, 16'h10, 16'h20, {1'b0, 1'b0, 16'h00F0}, 1'b0);
    run_op("k4_sub_b", 5, 1'b1, 16'h80, 16'h01, {1'b1, 1'b1, 16'h007F}, 1'b0);
    run_op("k2_wrap", 4, 1'b0, 16'hFF, 16'h01, {1'b0, 1'b1, 16'h0000}, 1'b1);
    run_op("kn_add", 6, 1'b0, 16'h7F, 16'h01, {1'b1, 1'b0, 16'h0080}, 1'b0);
    run_op("n4_sub", 0, 1'b1, 16'h0, 16'h8, {1'b1, 1'b0, 16'h0008}, 1'b0);

    // Back-to-back with Start held high, alternating Sub, on N=8 K=4
    prev = 16'h007F;
    sb = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    rx = a; ry = b; rsub = sb; rstart[5] = 1'b1;
    @(negedge clk);
    for (int op = 0; op < 6; op++) begin
      e = model(8, int'(a), int'(b), sb);
      cyc = 0;
      while (!rdone[5] && cyc < 32) begin
        chk("b2b_stable", rs[5], prev);
        cyc++;
        @(negedge clk);
      end
      chk("b2b_gap", cyc, 2);
      chk("b2b_s", rs[5], e[15:0]);
      chk("b2b_co", rco[5], e[16]);
      chk("b2b_ov", rov[5], e[17]);
      prev = e[15:0];
      a = 16'($urandom); b = 16'($urandom); sb = ~sb;
      rx = a; ry = b; rsub = sb;
      if (op == 5) rstart[5] = 1'b0;
      @(negedge clk);
    end
    chk("b2b_final_idle", rdone[5], 0);

    // Asynchronous reset three cycles into a K=1 operation
    rx = 16'h33; ry = 16'h44; rsub = 1'b0; rstart[3] = 1'b1;
    @(negedge clk);
    rstart[3] = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_s", rs[3], 0);
    chk("arst_co", rco[3], 0);
    chk("arst_ov", rov[3], 0);
    chk("arst_busy", rbusy[3], 0);
    chk("arst_done", rdone[3], 0);
    chk("arst_s_k4", rs[5], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("arst_no_done", rdone[3], 0);
    end
    run_op("arst_fresh", 3, 1'b1, 16'h05, 16'h07, {1'b0, 1'b0, 16'h00FE}, 1'b0);

    // Random regression across every configuration in parallel
    for (int op = 0; op < 1000; op++) begin
      a = 16'($urandom); b = 16'($urandom); sb = 1'($urandom_range(0, 1));
      rx = a; ry = b; rsub = sb; rstart = '1;
      @(negedge clk);
      rstart = '0;
      cyc = 0;
      while (rbusy != '0 && cyc < 64) begin
        cyc++;
        @(negedge clk);
      end
      chk("reg_timeout", rbusy, 0);
      for (int g = 0; g < C_NCFG; g++) begin
        e = model(cfg_n(g), int'(a), int'(b), sb);
        chk($sformatf("reg_n%0d_k%0d_s", cfg_n(g), cfg_k(g)), rs[g], e[15:0]);
        chk($sformatf("reg_n%0d_k%0d_co", cfg_n(g), cfg_k(g)), rco[g], e[16]);
        chk($sformatf("reg_n%0d_k%0d_ov", cfg_n(g), cfg_k(g)), rov[g], e[17]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
